up_ctrl_hs: RTL

Parametrised multicycle control unit for the RV64I-subset datapath. It succeeds the fixed-latency state machine: instruction- and data-memory accesses use a req/ack handshake with variable wait states and a configurable timeout. It also adds sticky error reporting and a retired-instruction counter. It sits beside the PC, IR, A/B, ALUOut and MDR registers, the register bank and the ALU, and drives all of their write enables and mux selects.

---
 rtl/up_ctrl_hs.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/up_ctrl_hs.sv
// Multicycle control unit for the RV64I-subset datapath. Memory accesses use a
// req/ack handshake with a wait timeout. Errors are sticky. Retired instructions are counted.
module up_ctrl_hs #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       op_code,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero_alu,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             load_ir,
  output logic             write_pc,
  output logic             write_reg_a,
  output logic             write_reg_b,
  output logic             wr_alu_out,
  output logic             wr_mdr,
  output logic             wr_banco_reg,
  output logic [1:0]       sel_mux_a,
  output logic [1:0]       sel_mux_b,
  output logic             sel_mux_data,
  output logic             pc_src,
  output logic [2:0]       operacao,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_LUI    = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_MEM_WB = 4'd8,
    S_MEM_WR = 4'd9,
    S_WB_ALU = 4'd10,
    S_BRANCH = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [2:0] r_op_s;
  logic       r_valid_s, i_valid_s, a_valid_s, br_valid_s, br_taken_s;
  logic       timeout_s, in_access_s, retire_s;

  // Instruction field decode shared by next-state and output logic
  always_comb begin
    r_op_s = 3'b000;
    if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
      r_op_s = 3'b001;
    end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
      r_op_s = 3'b010;
    end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
      r_op_s = 3'b011;
    end else begin
      r_op_s = 3'b000;
    end
    r_valid_s  = (r_op_s != 3'b000);
    i_valid_s  = (funct3 == 3'b000);
    a_valid_s  = (funct3 == 3'b011);
    br_valid_s = (funct3 == 3'b000) || (funct3 == 3'b001);
    br_taken_s = ((funct3 == 3'b000) && zero_alu) || ((funct3 == 3'b001) && !zero_alu);
    timeout_s  = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));
  end

  // State, wait counter, error code and retire counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_RESET;
      wait_q     <= '0;
      err_code_q <= 2'b00;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      err_code_q <= err_code_d;
      retired_q  <= retired_d;
    end
  end

  // Next-state decode; ack in the limit cycle takes priority over the timeout
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d    = S_ERROR;
          err_code_d = 2'b10;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op_code)
          7'b0110011: state_d = S_EXEC_R;
          7'b0010011: state_d = S_EXEC_I;
          7'b0000011: state_d = S_ADDR;
          7'b0100011: state_d = S_ADDR;
          7'b1100011: state_d = S_BRANCH;
          7'b0110111: state_d = S_LUI;
          default: begin
            state_d    = S_ERROR;
            err_code_d = 2'b01;
          end
        endcase
      end
      S_EXEC_R: begin
        if (r_valid_s) begin
          state_d = S_WB_ALU;
        end else begin
          state_d    = S_ERROR;
          err_code_d = 2'b01;
        end
      end
      S_EXEC_I: begin
        if (i_valid_s) begin
          state_d = S_WB_ALU;
        end else begin
          state_d    = S_ERROR;
          err_code_d = 2'b01;
        end
      end
      S_LUI: state_d = S_WB_ALU;
      S_ADDR: begin
        if (!a_valid_s) begin
          state_d    = S_ERROR;
          err_code_d = 2'b01;
        end else if (op_code == 7'b0000011) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        if (dmem_ack) begin
          state_d = S_MEM_WB;
        end else if (timeout_s) begin
          state_d    = S_ERROR;
          err_code_d = 2'b11;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        if (dmem_ack) begin
          state_d = S_FETCH;
        end else if (timeout_s) begin
          state_d    = S_ERROR;
          err_code_d = 2'b11;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_MEM_WB: state_d = S_FETCH;
      S_WB_ALU: state_d = S_FETCH;
      S_BRANCH: begin
        if (br_valid_s) begin
          state_d = S_FETCH;
        end else begin
          state_d    = S_ERROR;
          err_code_d = 2'b01;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: begin
        state_d    = S_RESET;
        err_code_d = 2'b00;
      end
    endcase
  end

  // Wait counter restarts whenever an access state is entered or left
  always_comb begin
    in_access_s = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    retire_s    = (state_d == S_FETCH) &&
                  ((state_q == S_WB_ALU) || (state_q == S_MEM_WB) ||
                   (state_q == S_MEM_WR) || (state_q == S_BRANCH));
    if (in_access_s && (state_d == state_q) && (MEM_TIMEOUT != 0)) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
    if (retire_s) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Control outputs decoded from the current state
  always_comb begin
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    load_ir      = 1'b0;
    write_pc     = 1'b0;
    write_reg_a  = 1'b0;
    write_reg_b  = 1'b0;
    wr_alu_out   = 1'b0;
    wr_mdr       = 1'b0;
    wr_banco_reg = 1'b0;
    sel_mux_a    = 2'b00;
    sel_mux_b    = 2'b00;
    sel_mux_data = 1'b0;
    pc_src       = 1'b0;
    operacao     = 3'b000;
    err          = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req  = 1'b1;
        sel_mux_b = 2'b01;
        operacao  = 3'b001;
        load_ir   = imem_ack;
        write_pc  = imem_ack;
      end
      S_DECODE: begin
        write_reg_a = 1'b1;
        write_reg_b = 1'b1;
        wr_alu_out  = 1'b1;
        sel_mux_b   = 2'b11;
        operacao    = 3'b001;
      end
      S_EXEC_R: begin
        sel_mux_a  = 2'b01;
        wr_alu_out = 1'b1;
        operacao   = r_op_s;
      end
      S_EXEC_I, S_ADDR: begin
        sel_mux_a  = 2'b01;
        sel_mux_b  = 2'b10;
        operacao   = 3'b001;
        wr_alu_out = 1'b1;
      end
      S_LUI: begin
        sel_mux_a  = 2'b10;
        sel_mux_b  = 2'b10;
        operacao   = 3'b001;
        wr_alu_out = 1'b1;
      end
      S_MEM_RD: begin
        dmem_req = 1'b1;
        wr_mdr   = dmem_ack;
      end
      S_MEM_WB: begin
        wr_banco_reg = 1'b1;
        sel_mux_data = 1'b1;
      end
      S_MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
      end
      S_WB_ALU: wr_banco_reg = 1'b1;
      S_BRANCH: begin
        sel_mux_a = 2'b01;
        operacao  = 3'b010;
        write_pc  = br_taken_s;
        pc_src    = br_taken_s;
      end
      S_ERROR: err = 1'b1;
      default: err = 1'b0;
    endcase
  end

  assign err_code = err_code_q;
  assign retired  = retired_q;

endmodule
